// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, freeze/flush handling
// and a saturating count of inserted load-use bubbles.
module idex_hazard_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [7:0]        id_ctrl,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [7:0]        ex_ctrl,
    output logic              load_use_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    // id_ctrl packing: {regwrite, memread, memwrite, memtoreg, alusrc, aluop[2:0]}
    localparam int unsigned CtrlMemRead = 6;

    logic              valid_q,   valid_d;
    logic [REG_W-1:0]  rs_q,      rs_d;
    logic [REG_W-1:0]  rt_q,      rt_d;
    logic [REG_W-1:0]  rd_q,      rd_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [DATA_W-1:0] pc4_q,     pc4_d;
    logic [7:0]        ctrl_q,    ctrl_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic load_use;
    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = (rt_q == id_rs);
    assign rt_hit   = id_uses_rt && (rt_q == id_rt);
    assign load_use = id_valid && valid_q && ctrl_q[CtrlMemRead] && (rt_q != '0)
                      && (rs_hit || rt_hit);

    assign load_use_o   = load_use;
    assign pc_write_o   = ~stall_i & ~load_use;
    assign ifid_write_o = ~stall_i & ~load_use;

    always_comb begin
        valid_d   = valid_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        pc4_d     = pc4_q;
        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;

        if (stall_i) begin
            // Freeze: everything holds, pending flush/hazard is re-evaluated later.
        end else if (flush_i || load_use) begin
            valid_d   = 1'b0;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            pc4_d     = '0;
            ctrl_d    = '0;
            if (!flush_i && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            valid_d   = id_valid;
            rs_d      = id_rs;
            rt_d      = id_rt;
            rd_d      = id_rd;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = id_imm;
            pc4_d     = id_pc4;
            ctrl_d    = id_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            pc4_q     <= '0;
            ctrl_q    <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            pc4_q     <= pc4_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_rs        = rs_q;
    assign ex_rt        = rt_q;
    assign ex_rd        = rd_q;
    assign ex_rs_data   = rs_data_q;
    assign ex_rt_data   = rt_data_q;
    assign ex_imm       = imm_q;
    assign ex_pc4       = pc4_q;
    assign ex_ctrl      = ctrl_q;
    assign bubble_cnt_o = cnt_q;

endmodule
